// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, jump, relative branch, call/return via a
// bounded return stack, soft reset and BIOS hand-off on a rising flagBios edge.
module pc_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       OFF_W       = 16,
  parameter int unsigned       STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter logic [ADDR_W-1:0] BOOT_ADDR   = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [2:0]                         sign,
  input  logic [ADDR_W-1:0]                  address,
  input  logic [OFF_W-1:0]                   offset,
  input  logic                               flagBios,
  output logic [ADDR_W-1:0]                  pc,
  output logic                               flagMuxBios,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_ovf,
  output logic                               stack_unf
);

  localparam int unsigned      CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned      PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(STACK_DEPTH);

  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_SOFT   = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_CALL   = 3'd5;
  localparam logic [2:0] OP_RET    = 3'd6;

  logic [ADDR_W-1:0] r_pc, w_pc_d, w_pc_inc, w_pc_rel;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_ovf, w_ovf_d, r_unf, w_unf_d;
  logic              r_prev_bios, w_boot, w_push;
  logic [PTR_W-1:0]  w_push_idx, w_pop_idx;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_pc_rel   = r_pc + ADDR_W'($signed(offset));
  assign w_push_idx = PTR_W'(r_cnt);
  assign w_pop_idx  = PTR_W'(r_cnt - CNT_W'(1));
  assign w_boot     = flagBios & ~r_prev_bios;

  always_comb begin
    w_pc_d  = r_pc;
    w_cnt_d = r_cnt;
    w_ovf_d = r_ovf;
    w_unf_d = r_unf;
    w_push  = 1'b0;
    // The boot hand-off wins over whatever operation is presented this cycle.
    if (w_boot) begin
      w_pc_d  = BOOT_ADDR;
      w_cnt_d = '0;
      w_ovf_d = 1'b0;
      w_unf_d = 1'b0;
    end else begin
      case (sign)
        OP_INC:    w_pc_d = w_pc_inc;
        OP_JUMP:   w_pc_d = address;
        OP_SOFT: begin
          w_pc_d  = RESET_ADDR;
          w_cnt_d = '0;
          w_ovf_d = 1'b0;
          w_unf_d = 1'b0;
        end
        OP_BRANCH: w_pc_d = w_pc_rel;
        OP_CALL: begin
          w_pc_d = address;
          if (r_cnt != FULL) begin
            w_push  = 1'b1;
            w_cnt_d = r_cnt + CNT_W'(1);
          end else begin
            w_ovf_d = 1'b1;
          end
        end
        OP_RET: begin
          if (r_cnt != '0) begin
            w_pc_d  = r_stack[w_pop_idx];
            w_cnt_d = r_cnt - CNT_W'(1);
          end else begin
            w_pc_d  = w_pc_inc;
            w_unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_ADDR;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_prev_bios <= 1'b0;
    end else begin
      r_pc        <= w_pc_d;
      r_cnt       <= w_cnt_d;
      r_ovf       <= w_ovf_d;
      r_unf       <= w_unf_d;
      r_prev_bios <= flagBios;
    end
  end

  // Entries above stack_count are meaningless, so the array needs no reset.
  always_ff @(posedge clock) begin
    if (w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign pc          = r_pc;
  assign flagMuxBios = r_prev_bios;
  assign stack_count = r_cnt;
  assign stack_ovf   = r_ovf;
  assign stack_unf   = r_unf;

endmodule
